// File: rtl/dmi_arbiter_if.sv
// Bundle of the two requester ports and the downstream DMI channel of dmi_arbiter.
// slave is the arbiter's view; master is the surrounding logic's view.
interface dmi_arbiter_if #(
  parameter int unsigned ADDR_W = 7,
  parameter int unsigned DATA_W = 32
);
  logic [1:0]          req_valid;
  logic [1:0]          req_ready;
  logic [2*ADDR_W-1:0] req_addr;
  logic [2*DATA_W-1:0] req_data;
  logic [3:0]          req_op;
  logic [1:0]          resp_valid;
  logic [1:0]          resp_ready;
  logic [DATA_W-1:0]   resp_data;
  logic [1:0]          resp_resp;
  logic                dmi_req_valid;
  logic                dmi_req_ready;
  logic [ADDR_W-1:0]   dmi_req_addr;
  logic [DATA_W-1:0]   dmi_req_data;
  logic [1:0]          dmi_req_op;
  logic                dmi_resp_valid;
  logic                dmi_resp_ready;
  logic [DATA_W-1:0]   dmi_resp_data;
  logic [1:0]          dmi_resp_resp;
  logic                busy;

  modport slave (
    input  req_valid, req_addr, req_data, req_op, resp_ready,
           dmi_req_ready, dmi_resp_valid, dmi_resp_data, dmi_resp_resp,
    output req_ready, resp_valid, resp_data, resp_resp,
           dmi_req_valid, dmi_req_addr, dmi_req_data, dmi_req_op, dmi_resp_ready, busy
  );

  modport master (
    output req_valid, req_addr, req_data, req_op, resp_ready,
           dmi_req_ready, dmi_resp_valid, dmi_resp_data, dmi_resp_resp,
    input  req_ready, resp_valid, resp_data, resp_resp,
           dmi_req_valid, dmi_req_addr, dmi_req_data, dmi_req_op, dmi_resp_ready, busy
  );
endinterface

// File: rtl/dmi_arbiter.sv
// Round-robin arbiter sharing one DMI channel between the JTAG DTM (0) and system DAP (1).
// Define DMI_ARB_TIMEOUT_EN to abort stalled WAITs after TIMEOUT cycles and drain the late reply.
module dmi_arbiter #(
  parameter int unsigned ADDR_W  = 7,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input logic          clock,
  input logic          reset,
  dmi_arbiter_if.slave bus
);

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StWait,
    StResp
`ifdef DMI_ARB_TIMEOUT_EN
    ,
    StDrain
`endif
  } state_e;

  state_e            state_q;
  logic              owner_q;
  logic              ptr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic [1:0]        op_q;
  logic              dmi_req_valid_q;
  logic              dmi_resp_ready_q;
  logic [1:0]        resp_valid_q;
  logic [DATA_W-1:0] resp_data_q;
  logic [1:0]        resp_resp_q;
  logic              busy_q;

`ifdef DMI_ARB_TIMEOUT_EN
  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);
  logic [7:0] cnt_q;
  logic       abort_q;
`endif

  logic              winner;
  logic [1:0]        grant;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;
  logic [1:0]        sel_op;
  logic              sel_xfer;

  always_comb begin
    grant  = 2'b00;
    winner = 1'b0;
    if (state_q == StIdle && !reset) begin
      case (bus.req_valid)
        2'b01:   begin grant = 2'b01; winner = 1'b0;  end
        2'b10:   begin grant = 2'b10; winner = 1'b1;  end
        2'b11:   begin grant = ptr_q ? 2'b10 : 2'b01; winner = ptr_q; end
        default: ;
      endcase
    end
    sel_addr = winner ? bus.req_addr[2*ADDR_W-1:ADDR_W] : bus.req_addr[ADDR_W-1:0];
    sel_data = winner ? bus.req_data[2*DATA_W-1:DATA_W] : bus.req_data[DATA_W-1:0];
    sel_op   = winner ? bus.req_op[3:2] : bus.req_op[1:0];
    // Only read and write reach the bridge; NOP and reserved complete locally.
    sel_xfer = (sel_op == 2'd1) || (sel_op == 2'd2);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q          <= StIdle;
      owner_q          <= 1'b0;
      ptr_q            <= 1'b0;
      addr_q           <= '0;
      data_q           <= '0;
      op_q             <= 2'd0;
      dmi_req_valid_q  <= 1'b0;
      dmi_resp_ready_q <= 1'b0;
      resp_valid_q     <= 2'b00;
      resp_data_q      <= '0;
      resp_resp_q      <= 2'd0;
      busy_q           <= 1'b0;
`ifdef DMI_ARB_TIMEOUT_EN
      cnt_q            <= 8'd0;
      abort_q          <= 1'b0;
`endif
    end else begin
      case (state_q)
        StIdle: begin
          if (|grant) begin
            owner_q <= winner;
            ptr_q   <= ~winner;
            addr_q  <= sel_addr;
            data_q  <= sel_data;
            op_q    <= sel_op;
            busy_q  <= 1'b1;
            if (sel_xfer) begin
              state_q         <= StReq;
              dmi_req_valid_q <= 1'b1;
            end else begin
              state_q      <= StResp;
              resp_valid_q <= grant;
              resp_data_q  <= '0;
              resp_resp_q  <= 2'd0;
            end
          end
        end
        StReq: begin
          if (bus.dmi_req_ready) begin
            state_q          <= StWait;
            dmi_req_valid_q  <= 1'b0;
            dmi_resp_ready_q <= 1'b1;
`ifdef DMI_ARB_TIMEOUT_EN
            cnt_q            <= 8'd0;
`endif
          end
        end
        StWait: begin
          // A reply in the terminal cycle takes precedence over the abort.
          if (bus.dmi_resp_valid) begin
            state_q          <= StResp;
            dmi_resp_ready_q <= 1'b0;
            resp_valid_q     <= owner_q ? 2'b10 : 2'b01;
            resp_data_q      <= bus.dmi_resp_data;
            resp_resp_q      <= bus.dmi_resp_resp;
          end
`ifdef DMI_ARB_TIMEOUT_EN
          else if (cnt_q == TimeoutLast) begin
            state_q          <= StResp;
            dmi_resp_ready_q <= 1'b0;
            resp_valid_q     <= owner_q ? 2'b10 : 2'b01;
            resp_data_q      <= '0;
            resp_resp_q      <= 2'd2;
            abort_q          <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
`endif
        end
        StResp: begin
          if (bus.resp_ready[owner_q]) begin
            resp_valid_q <= 2'b00;
`ifdef DMI_ARB_TIMEOUT_EN
            if (abort_q) begin
              state_q          <= StDrain;
              dmi_resp_ready_q <= 1'b1;
              abort_q          <= 1'b0;
            end else begin
              state_q <= StIdle;
              busy_q  <= 1'b0;
            end
`else
            state_q <= StIdle;
            busy_q  <= 1'b0;
`endif
          end
        end
`ifdef DMI_ARB_TIMEOUT_EN
        StDrain: begin
          if (bus.dmi_resp_valid) begin
            state_q          <= StIdle;
            dmi_resp_ready_q <= 1'b0;
            busy_q           <= 1'b0;
          end
        end
`endif
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.req_ready      = grant;
  assign bus.resp_valid     = resp_valid_q;
  assign bus.resp_data      = resp_data_q;
  assign bus.resp_resp      = resp_resp_q;
  assign bus.dmi_req_valid  = dmi_req_valid_q;
  assign bus.dmi_req_addr   = addr_q;
  assign bus.dmi_req_data   = data_q;
  assign bus.dmi_req_op     = op_q;
  assign bus.dmi_resp_ready = dmi_resp_ready_q;
  assign bus.busy           = busy_q;

endmodule

// File: doc/dmi_arbiter.md
# dmi_arbiter

Round-robin arbiter and sequencer that shares the single Debug Module Interface (DMI) request/response channel between two requesters: requester 0 is the JTAG DTM and requester 1 is the system-side debug access port. It sits between the requesters and the DMI-to-TileLink bridge that feeds the debug crossbar. It allows one outstanding transaction and returns each response to the requester that issued it. It completes NOP requests locally and, when configured, abandons stalled transactions after a timeout.

## Interface
- ADDR_W, 7, DMI address width
- DATA_W, 32, DMI data width
- TIMEOUT, 255, number of WAIT cycles before abort (8-bit counter, 1..255)
- clock  in  1  single clock for all logic
- reset  in  1  asynchronous, active-high reset
- req_valid  in  2  per-requester request valid (bit i = requester i)
- req_ready  out  2  per-requester request accept
- req_addr  in  2×ADDR_W  per-requester address, packed
- req_data  in  2×DATA_W  per-requester write data, packed
- req_op  in  2×2  per-requester op: 0 NOP, 1 read, 2 write, 3 reserved (treated as NOP)
- resp_valid  out  2  per-requester response valid
- resp_ready  in  2  per-requester response accept
- resp_data  out  DATA_W  response data, shared, qualified by resp_valid
- resp_resp  out  2  response code: 0 success, 2 failed, 3 busy
- dmi_req_valid / dmi_req_ready  out / in  1  downstream request handshake
- dmi_req_addr, dmi_req_data, dmi_req_op  out  ADDR_W, DATA_W, 2  registered downstream fields
- dmi_resp_valid / dmi_resp_ready  in / out  1  downstream response handshake
- dmi_resp_data, dmi_resp_resp  in  DATA_W, 2  downstream response payload
- busy  out  1  high whenever state ≠ IDLE

## Operation
- States: IDLE, REQ, WAIT, RESP, DRAIN. Reset puts the block in IDLE.
- Reset values: all outputs 0. Priority pointer = 0 (requester 0 favoured). Capture registers = 0. Timeout counter = 0.
- IDLE arbitration:
  - If only one requester is valid, it wins.
  - If both are valid, the pointer's requester wins.
  - req_ready is asserted combinationally to the winner only.
  - On the handshake, latch owner, addr, data and op, and set the pointer to ~owner.
- NOP or reserved op: skip the downstream channel. Go directly to RESP with resp_data=0 and resp_resp=0.
- REQ: hold dmi_req_valid=1 with the latched fields until dmi_req_ready=1, then go to WAIT.
- WAIT:
  - Hold dmi_resp_ready=1.
  - On dmi_resp_valid, latch the data and response code, then go to RESP.
- RESP:
  - Assert resp_valid[owner] only; the other requester's bit stays 0.
  - Hold until resp_ready[owner]=1, then go to IDLE.
- The arbiter never issues a second request while a transaction is outstanding. resp_* of the non-owner is never asserted.
- Reset asserted mid-transaction returns the block to IDLE immediately. Outstanding state is discarded; downstream cleanup is the bridge's responsibility under the same reset.

## Timing
- Request accepted in cycle 0 → dmi_req_valid in cycle 1.
- With dmi_req_ready=1 in cycle 1 and dmi_resp_valid=1 in cycle 2, resp_valid goes high in cycle 3. This is the minimum 3-cycle accept-to-response latency.
- A NOP accepted in cycle 0 → resp_valid in cycle 1.
- With resp_ready held high, back-to-back transactions restart arbitration in the cycle after the response handshake.
- dmi_resp_ready=0 outside WAIT and DRAIN. A downstream response in those states is not consumed.

## Configuration
- Macro: DMI_ARB_TIMEOUT_EN.
- Defined:
  - WAIT increments an 8-bit counter every cycle.
  - When the counter reaches TIMEOUT without dmi_resp_valid, go to RESP with resp_resp=2 and resp_data=0.
  - After that response handshake, go to DRAIN instead of IDLE.
  - DRAIN holds dmi_resp_ready=1, discards exactly one late response, then goes to IDLE. No grants are made in DRAIN.
  - A response arriving in the same cycle the counter hits TIMEOUT wins: normal completion, no abort.
  - The counter clears on entry to WAIT.
- Undefined: no counter and no DRAIN state. WAIT lasts until dmi_resp_valid.

## Test plan
- Single read: req 0 asserts op=1, addr=0x11. Downstream returns data=0xDEADBEEF, resp=0 → resp_valid[0]=1 with data 0xDEADBEEF, resp_valid[1]=0, latency 3 cycles.
- Contention: both requesters hold valid writes (addr 0x10 and 0x04) continuously → grants alternate 0,1,0,1. Each response goes only to its issuer.
- NOP: req 1 asserts op=0 → no dmi_req_valid; resp_valid[1]=1 in the next cycle with resp=0, data=0.
- Backpressure: dmi_req_ready held 0 for 5 cycles and resp_ready[0] held 0 for 4 cycles → the latched fields and response stay stable, and no new grant is made.
- Timeout (DMI_ARB_TIMEOUT_EN, TIMEOUT=8): downstream is silent → resp_resp=2 after 8 WAIT cycles. A late response is absorbed in DRAIN, and busy drops afterwards.
- Reset mid-WAIT: reset pulsed during WAIT → all outputs 0 and state IDLE. After reset, the first request issues normally.
